// File: rtl/stencil_job_queue.sv
// AXI-Lite controlled job queue that feeds {SIZE, SRC, DST} descriptors to a stencil
// coprocessor one at a time, counting completions and raising a level interrupt when drained.
module stencil_job_queue #(
    parameter int QDEPTH = 4,
    parameter int SIZE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,

    input  logic [4:0]        AXI_CTRL_AWADDR,
    input  logic [2:0]        AXI_CTRL_AWPROT,
    input  logic              AXI_CTRL_AWVALID,
    output logic              AXI_CTRL_AWREADY,
    input  logic [31:0]       AXI_CTRL_WDATA,
    input  logic [3:0]        AXI_CTRL_WSTRB,
    input  logic              AXI_CTRL_WVALID,
    output logic              AXI_CTRL_WREADY,
    output logic [1:0]        AXI_CTRL_BRESP,
    output logic              AXI_CTRL_BVALID,
    input  logic              AXI_CTRL_BREADY,
    input  logic [4:0]        AXI_CTRL_ARADDR,
    input  logic [2:0]        AXI_CTRL_ARPROT,
    input  logic              AXI_CTRL_ARVALID,
    output logic              AXI_CTRL_ARREADY,
    output logic [31:0]       AXI_CTRL_RDATA,
    output logic [1:0]        AXI_CTRL_RRESP,
    output logic              AXI_CTRL_RVALID,
    input  logic              AXI_CTRL_RREADY,

    output logic [SIZE_W-1:0] STENCIL_SIZE,
    output logic [31:0]       STENCIL_SRC,
    output logic [31:0]       STENCIL_DST,
    output logic              STENCIL_GO,
    input  logic              STENCIL_DONE,

    output logic              IRQ
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int LVL_W = $clog2(QDEPTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SIZE_W-1:0] sizeStage_q;
    logic [31:0]       srcStage_q, dstStage_q;
    logic              irqEn_q;
    logic              bvalid_q, rvalid_q;
    logic [31:0]       rdata_q;
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              irq_q;
    logic [SIZE_W-1:0] sizeOut_q;
    logic [31:0]       srcOut_q, dstOut_q;

    logic [SIZE_W-1:0] qSize_q [QDEPTH];
    logic [31:0]       qSrc_q  [QDEPTH];
    logic [31:0]       qDst_q  [QDEPTH];

    logic        wrFire, rdFire, ctrlWr;
    logic        pushReq, pushAcc, pop, clrCnt, clrOvf;
    logic        full, empty, busy, completion;
    logic [31:0] rdMux;
    logic        unused_inputs;

    assign unused_inputs = ^{AXI_CTRL_AWPROT, AXI_CTRL_WSTRB, AXI_CTRL_ARPROT};

    assign wrFire = ARESETN & AXI_CTRL_AWVALID & AXI_CTRL_WVALID & ~bvalid_q;
    assign rdFire = ARESETN & AXI_CTRL_ARVALID & ~rvalid_q;

    assign AXI_CTRL_AWREADY = wrFire;
    assign AXI_CTRL_WREADY  = wrFire;
    assign AXI_CTRL_BVALID  = bvalid_q;
    assign AXI_CTRL_BRESP   = 2'b00;
    assign AXI_CTRL_ARREADY = rdFire;
    assign AXI_CTRL_RVALID  = rvalid_q;
    assign AXI_CTRL_RDATA   = rdata_q;
    assign AXI_CTRL_RRESP   = 2'b00;

    assign ctrlWr  = wrFire & (AXI_CTRL_AWADDR == 5'h0C);
    assign pushReq = ctrlWr & AXI_CTRL_WDATA[0];
    assign clrCnt  = ctrlWr & AXI_CTRL_WDATA[1];
    assign clrOvf  = ctrlWr & AXI_CTRL_WDATA[2];

    assign full  = (level_q == LVL_W'(QDEPTH));
    assign empty = (level_q == '0);
    assign busy  = (state_q != IDLE);

    // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
    assign pop        = (state_q == IDLE) & ~empty & STENCIL_DONE;
    assign pushAcc    = pushReq & (~full | pop);
    assign completion = (pop & (qSize_q[rdPtr_q] == '0)) | ((state_q == WAIT) & STENCIL_DONE);

    assign STENCIL_GO   = (state_q == LAUNCH);
    assign STENCIL_SIZE = sizeOut_q;
    assign STENCIL_SRC  = srcOut_q;
    assign STENCIL_DST  = dstOut_q;
    assign IRQ          = irq_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop && qSize_q[rdPtr_q] != '0) state_d = LAUNCH;
            LAUNCH:  state_d = SETTLE;
            SETTLE:  state_d = WAIT;
            WAIT:    if (STENCIL_DONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (pushAcc && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!pushAcc && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        cnt_d = cnt_q + (completion ? CNT_W'(1) : CNT_W'(0));
        if (clrCnt) begin
            cnt_d = completion ? CNT_W'(1) : CNT_W'(0);
        end

        ovf_d = ovf_q;
        if (pushReq && full && !pop) begin
            ovf_d = 1'b1;
        end else if (clrOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rdMux = '0;
        case (AXI_CTRL_ARADDR)
            5'h00:   rdMux = 32'(sizeStage_q);
            5'h04:   rdMux = srcStage_q;
            5'h08:   rdMux = dstStage_q;
            5'h0C:   rdMux = {30'd0, irqEn_q, 1'b0};
            5'h10:   rdMux = {16'(cnt_q), 2'b00, 6'(level_q), 4'b0000, ovf_q, busy, full, empty};
            5'h14:   rdMux = {31'd0, irqEn_q};
            default: rdMux = '0;
        endcase
    end

    // Entry storage needs no reset: level and pointers alone decide what is valid.
    always_ff @(posedge ACLK) begin
        if (pushAcc) begin
            qSize_q[wrPtr_q] <= sizeStage_q;
            qSrc_q[wrPtr_q]  <= srcStage_q;
            qDst_q[wrPtr_q]  <= dstStage_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            sizeStage_q <= '0;
            srcStage_q  <= '0;
            dstStage_q  <= '0;
            irqEn_q     <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            sizeOut_q   <= '0;
            srcOut_q    <= '0;
            dstOut_q    <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            irq_q   <= irqEn_q & (cnt_q != '0) & empty & ~busy;

            if (wrFire) begin
                case (AXI_CTRL_AWADDR)
                    5'h00:   sizeStage_q <= SIZE_W'(AXI_CTRL_WDATA);
                    5'h04:   srcStage_q  <= AXI_CTRL_WDATA;
                    5'h08:   dstStage_q  <= AXI_CTRL_WDATA;
                    5'h14:   irqEn_q     <= AXI_CTRL_WDATA[0];
                    default: ;
                endcase
            end

            if (wrFire) begin
                bvalid_q <= 1'b1;
            end else if (AXI_CTRL_BREADY) begin
                bvalid_q <= 1'b0;
            end

            if (rdFire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdMux;
            end else if (AXI_CTRL_RREADY) begin
                rvalid_q <= 1'b0;
            end

            if (pushAcc) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q   <= rdPtr_q + PTR_W'(1);
                sizeOut_q <= qSize_q[rdPtr_q];
                srcOut_q  <= qSrc_q[rdPtr_q];
                dstOut_q  <= qDst_q[rdPtr_q];
            end
        end
    end

endmodule

// File: tb/tb_stencil_job_queue.sv
// Directed bench for stencil_job_queue: AXI-Lite register programming, a launch scoreboard
// checked on every GO pulse, and status/IRQ/reset checks against hand-derived values.
module tb_stencil_job_queue;

    localparam int QDEPTH = 4;
    localparam int SIZE_W = 16;
    localparam int CNT_W  = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [4:0]        AXI_CTRL_AWADDR;
    logic [2:0]        AXI_CTRL_AWPROT;
    logic              AXI_CTRL_AWVALID;
    logic              AXI_CTRL_AWREADY;
    logic [31:0]       AXI_CTRL_WDATA;
    logic [3:0]        AXI_CTRL_WSTRB;
    logic              AXI_CTRL_WVALID;
    logic              AXI_CTRL_WREADY;
    logic [1:0]        AXI_CTRL_BRESP;
    logic              AXI_CTRL_BVALID;
    logic              AXI_CTRL_BREADY;
    logic [4:0]        AXI_CTRL_ARADDR;
    logic [2:0]        AXI_CTRL_ARPROT;
    logic              AXI_CTRL_ARVALID;
    logic              AXI_CTRL_ARREADY;
    logic [31:0]       AXI_CTRL_RDATA;
    logic [1:0]        AXI_CTRL_RRESP;
    logic              AXI_CTRL_RVALID;
    logic              AXI_CTRL_RREADY;
    logic [SIZE_W-1:0] STENCIL_SIZE;
    logic [31:0]       STENCIL_SRC;
    logic [31:0]       STENCIL_DST;
    logic              STENCIL_GO;
    logic              STENCIL_DONE;
    logic              IRQ;

    stencil_job_queue #(.QDEPTH(QDEPTH), .SIZE_W(SIZE_W), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AXI_CTRL_AWADDR(AXI_CTRL_AWADDR), .AXI_CTRL_AWPROT(AXI_CTRL_AWPROT),
        .AXI_CTRL_AWVALID(AXI_CTRL_AWVALID), .AXI_CTRL_AWREADY(AXI_CTRL_AWREADY),
        .AXI_CTRL_WDATA(AXI_CTRL_WDATA), .AXI_CTRL_WSTRB(AXI_CTRL_WSTRB),
        .AXI_CTRL_WVALID(AXI_CTRL_WVALID), .AXI_CTRL_WREADY(AXI_CTRL_WREADY),
        .AXI_CTRL_BRESP(AXI_CTRL_BRESP), .AXI_CTRL_BVALID(AXI_CTRL_BVALID),
        .AXI_CTRL_BREADY(AXI_CTRL_BREADY),
        .AXI_CTRL_ARADDR(AXI_CTRL_ARADDR), .AXI_CTRL_ARPROT(AXI_CTRL_ARPROT),
        .AXI_CTRL_ARVALID(AXI_CTRL_ARVALID), .AXI_CTRL_ARREADY(AXI_CTRL_ARREADY),
        .AXI_CTRL_RDATA(AXI_CTRL_RDATA), .AXI_CTRL_RRESP(AXI_CTRL_RRESP),
        .AXI_CTRL_RVALID(AXI_CTRL_RVALID), .AXI_CTRL_RREADY(AXI_CTRL_RREADY),
        .STENCIL_SIZE(STENCIL_SIZE), .STENCIL_SRC(STENCIL_SRC), .STENCIL_DST(STENCIL_DST),
        .STENCIL_GO(STENCIL_GO), .STENCIL_DONE(STENCIL_DONE), .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [31:0]       src;
        logic [31:0]       dst;
    } job_t;

    job_t sbQueue[$];
    job_t expJob;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    int   goCount    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Every GO pulse must match the oldest job the bench expects to be launched.
    always @(negedge ACLK) begin
        if (ARESETN === 1'b1 && STENCIL_GO === 1'b1) begin
            goCount++;
            checkOutput("goExpected", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                expJob = sbQueue.pop_front();
                checkOutput("goSize", 32'(STENCIL_SIZE), 32'(expJob.size));
                checkOutput("goSrc", STENCIL_SRC, expJob.src);
                checkOutput("goDst", STENCIL_DST, expJob.dst);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data);
        int n = 0;
        AXI_CTRL_AWADDR  = addr;
        AXI_CTRL_WDATA   = data;
        AXI_CTRL_AWVALID = 1'b1;
        AXI_CTRL_WVALID  = 1'b1;
        #1;
        while (AXI_CTRL_AWREADY !== 1'b1 && n < 20) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (AXI_CTRL_AWREADY !== 1'b1) begin
            checkOutput("awTimeout", 32'd0, 32'd1);
        end else begin
            @(posedge ACLK);
            #1;
            checkOutput("bvalid", 32'(AXI_CTRL_BVALID), 32'd1);
        end
        AXI_CTRL_AWVALID = 1'b0;
        AXI_CTRL_WVALID  = 1'b0;
    endtask

    task automatic axiRead(input logic [4:0] addr, output logic [31:0] data);
        int n = 0;
        AXI_CTRL_ARADDR  = addr;
        AXI_CTRL_ARVALID = 1'b1;
        #1;
        while (AXI_CTRL_ARREADY !== 1'b1 && n < 20) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        data = 32'hDEAD_BEEF;
        if (AXI_CTRL_ARREADY !== 1'b1) begin
            checkOutput("arTimeout", 32'd0, 32'd1);
        end else begin
            @(posedge ACLK);
            #1;
            checkOutput("rvalid", 32'(AXI_CTRL_RVALID), 32'd1);
            data = AXI_CTRL_RDATA;
        end
        AXI_CTRL_ARVALID = 1'b0;
    endtask

    task automatic readCheck(input logic [4:0] addr, input logic [31:0] expected, input string tag);
        logic [31:0] data;
        axiRead(addr, data);
        checkOutput(tag, data, expected);
    endtask

    // Stages a job and pushes it; only jobs expected to reach GO go on the scoreboard.
    task automatic applyStimulus(input logic [SIZE_W-1:0] size, input logic [31:0] src,
                                 input logic [31:0] dst, input bit launch);
        job_t j;
        axiWrite(5'h00, 32'(size));
        axiWrite(5'h04, src);
        axiWrite(5'h08, dst);
        if (launch && size != '0) begin
            j.size = size;
            j.src  = src;
            j.dst  = dst;
            sbQueue.push_back(j);
        end
        axiWrite(5'h0C, 32'h1);
    endtask

    task automatic waitGo(input int maxCycles);
        int n = 0;
        while (STENCIL_GO !== 1'b1 && n < maxCycles) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (STENCIL_GO !== 1'b1) checkOutput("goTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        int baseGo;
        int n;
        ARESETN          = 1'b0;
        AXI_CTRL_AWADDR  = '0;
        AXI_CTRL_AWPROT  = '0;
        AXI_CTRL_AWVALID = 1'b0;
        AXI_CTRL_WDATA   = '0;
        AXI_CTRL_WSTRB   = 4'hF;
        AXI_CTRL_WVALID  = 1'b0;
        AXI_CTRL_BREADY  = 1'b1;
        AXI_CTRL_ARADDR  = '0;
        AXI_CTRL_ARPROT  = '0;
        AXI_CTRL_ARVALID = 1'b0;
        AXI_CTRL_RREADY  = 1'b1;
        STENCIL_DONE     = 1'b1;
        cycles(3);
        checkOutput("rstGo", 32'(STENCIL_GO), 32'd0);
        checkOutput("rstIrq", 32'(IRQ), 32'd0);
        checkOutput("rstBvalid", 32'(AXI_CTRL_BVALID), 32'd0);
        checkOutput("rstRvalid", 32'(AXI_CTRL_RVALID), 32'd0);
        checkOutput("rstRdata", AXI_CTRL_RDATA, 32'd0);
        checkOutput("rstSize", 32'(STENCIL_SIZE), 32'd0);
        ARESETN = 1'b1;
        cycles(1);
        readCheck(5'h10, 32'h0000_0001, "statusAfterReset");

        $display("[TB] single job launch and completion");
        applyStimulus(16'd8, 32'h1000, 32'h2000, 1'b1);
        waitGo(20);
        STENCIL_DONE = 1'b0;
        cycles(1);
        checkOutput("goPulseWidth", 32'(STENCIL_GO), 32'd0);
        cycles(2);
        STENCIL_DONE = 1'b1;
        cycles(3);
        readCheck(5'h10, 32'h0001_0001, "statusAfterJob");
        readCheck(5'h00, 32'd8, "sizeStagingKept");
        readCheck(5'h08, 32'h2000, "dstStagingKept");
        readCheck(5'h18, 32'h0, "unmappedRead");

        $display("[TB] overflow with five pushes into four slots");
        axiWrite(5'h0C, 32'h2);
        STENCIL_DONE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(SIZE_W'(3 + i), 32'hA000 + 32'(i) * 32'h100, 32'hB000 + 32'(i), i < 4);
        end
        readCheck(5'h10, 32'h0000_040A, "statusFullOvf");
        baseGo = goCount;
        STENCIL_DONE = 1'b1;
        cycles(30);
        checkOutput("ovfGoCount", 32'(goCount - baseGo), 32'd4);
        checkOutput("ovfScoreboardEmpty", 32'(sbQueue.size()), 32'd0);
        readCheck(5'h10, 32'h0004_0009, "statusDrainedOvf");
        axiWrite(5'h0C, 32'h4);
        readCheck(5'h10, 32'h0004_0001, "statusOvfCleared");

        $display("[TB] zero-size job is counted but not launched");
        axiWrite(5'h0C, 32'h2);
        baseGo = goCount;
        applyStimulus(16'd0, 32'h5, 32'h6, 1'b1);
        applyStimulus(16'd4, 32'h3000, 32'h4000, 1'b1);
        cycles(20);
        checkOutput("zeroSizeGoCount", 32'(goCount - baseGo), 32'd1);
        readCheck(5'h10, 32'h0002_0001, "statusZeroSize");

        $display("[TB] interrupt timing");
        axiWrite(5'h0C, 32'h2);
        axiWrite(5'h14, 32'h1);
        cycles(2);
        checkOutput("irqCntZero", 32'(IRQ), 32'd0);
        readCheck(5'h0C, 32'h2, "ctrlReadIrqEn");
        readCheck(5'h14, 32'h1, "irqEnRead");
        applyStimulus(16'd5, 32'h7000, 32'h8000, 1'b1);
        waitGo(20);
        STENCIL_DONE = 1'b0;
        cycles(3);
        checkOutput("irqWhileBusy", 32'(IRQ), 32'd0);
        STENCIL_DONE = 1'b1;
        cycles(1);
        checkOutput("irqRegDelay", 32'(IRQ), 32'd0);
        cycles(1);
        checkOutput("irqRaised", 32'(IRQ), 32'd1);
        axiWrite(5'h0C, 32'h2);
        checkOutput("irqHeldAtClr", 32'(IRQ), 32'd1);
        cycles(1);
        checkOutput("irqCleared", 32'(IRQ), 32'd0);

        $display("[TB] read back-pressure during completion");
        applyStimulus(16'd6, 32'h9000, 32'h9100, 1'b1);
        waitGo(20);
        STENCIL_DONE = 1'b0;
        cycles(3);
        AXI_CTRL_RREADY  = 1'b0;
        AXI_CTRL_ARADDR  = 5'h10;
        AXI_CTRL_ARVALID = 1'b1;
        #1;
        n = 0;
        while (AXI_CTRL_ARREADY !== 1'b1 && n < 20) begin
            cycles(1);
            n++;
        end
        checkOutput("arReadyStall", 32'(AXI_CTRL_ARREADY), 32'd1);
        cycles(1);
        AXI_CTRL_ARVALID = 1'b0;
        checkOutput("statusBusyRead", AXI_CTRL_RDATA, 32'h0000_0005);
        STENCIL_DONE = 1'b1;
        cycles(4);
        checkOutput("rdataHeld", AXI_CTRL_RDATA, 32'h0000_0005);
        checkOutput("rvalidHeld", 32'(AXI_CTRL_RVALID), 32'd1);
        AXI_CTRL_RREADY = 1'b1;
        cycles(1);
        checkOutput("rvalidCleared", 32'(AXI_CTRL_RVALID), 32'd0);
        readCheck(5'h10, 32'h0001_0001, "statusAfterStall");

        $display("[TB] reset in the middle of a job");
        applyStimulus(16'd7, 32'hC000, 32'hC100, 1'b1);
        waitGo(20);
        STENCIL_DONE = 1'b0;
        applyStimulus(16'd9, 32'hD000, 32'hD100, 1'b0);
        applyStimulus(16'd10, 32'hE000, 32'hE100, 1'b0);
        readCheck(5'h10, 32'h0001_0204, "statusTwoQueued");
        #2;
        ARESETN = 1'b0;
        #1;
        checkOutput("midRstGo", 32'(STENCIL_GO), 32'd0);
        checkOutput("midRstIrq", 32'(IRQ), 32'd0);
        checkOutput("midRstSize", 32'(STENCIL_SIZE), 32'd0);
        checkOutput("midRstSrc", STENCIL_SRC, 32'd0);
        checkOutput("midRstDst", STENCIL_DST, 32'd0);
        checkOutput("midRstRdata", AXI_CTRL_RDATA, 32'd0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        STENCIL_DONE = 1'b1;
        baseGo = goCount;
        cycles(15);
        checkOutput("noGoAfterReset", 32'(goCount - baseGo), 32'd0);
        readCheck(5'h10, 32'h0000_0001, "statusAfterMidReset");
        readCheck(5'h14, 32'h0, "irqEnAfterReset");
        readCheck(5'h00, 32'h0, "sizeStagingAfterReset");
        applyStimulus(16'd11, 32'hF000, 32'hF100, 1'b1);
        waitGo(20);
        cycles(6);
        checkOutput("finalScoreboardEmpty", 32'(sbQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
